serial_out_prog: RTL and testbench

Parametrised successor of the fixed-rate serial pattern generator. Serially shifts out an N-bit output pattern LSB first. Each bit's duration is selected per bit by a frequency pattern, choosing between two run-time programmable periods. Adds programmable pattern length and a pass count (one-shot, N passes or continuous), and sits between the register/UART command block and the output pin driver.

---
 rtl/serial_out_prog_if.sv | 34 +++
 rtl/serial_out_prog.sv | 179 +++++++++++++++++
 tb/tb_serial_out_prog.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_out_prog_if.sv
// Command/status bundle between the register block and serial_out_prog.
// master: command side (drives i_*), slave: generator (drives o_*).
interface serial_out_prog_if #(
    parameter int DATA_BIT = 32,
    parameter int CNT_BIT  = 8,
    parameter int REP_BIT  = 8
);
    localparam int LEN_BIT = $clog2(DATA_BIT) + 1;

    logic                i_start;
    logic                i_stop;
    logic [DATA_BIT-1:0] i_output_pattern;
    logic [DATA_BIT-1:0] i_freq_pattern;
    logic [LEN_BIT-1:0]  i_bit_len;
    logic [CNT_BIT-1:0]  i_high_period;
    logic [CNT_BIT-1:0]  i_low_period;
    logic [REP_BIT-1:0]  i_repeat_num;
    logic                o_serial_out;
    logic                o_bit_tick;
    logic                o_done_tick;
    logic                o_busy;

    modport master (
        output i_start, i_stop, i_output_pattern, i_freq_pattern,
        output i_bit_len, i_high_period, i_low_period, i_repeat_num,
        input  o_serial_out, o_bit_tick, o_done_tick, o_busy
    );

    modport slave (
        input  i_start, i_stop, i_output_pattern, i_freq_pattern,
        input  i_bit_len, i_high_period, i_low_period, i_repeat_num,
        output o_serial_out, o_bit_tick, o_done_tick, o_busy
    );
endinterface

// File: rtl/serial_out_prog.sv
// Programmable serial pattern generator: shifts a pattern out LSB first,
// each bit lasting the high or low period chosen by the frequency pattern.
// Ports: clk, rst (sync, active-high), bus (serial_out_prog_if.slave).
// Optional macro SERIAL_OUT_SHADOW_EN: i_start while shifting is queued in
// a shadow config and taken at the next pass end instead of restarting.
module serial_out_prog #(
    parameter int DATA_BIT   = 32,
    parameter int CNT_BIT    = 8,
    parameter int REP_BIT    = 8,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input logic clk,
    input logic rst,
    serial_out_prog_if.slave bus
);
    localparam int LW = $clog2(DATA_BIT) + 1;
    localparam int IW = $clog2(DATA_BIT);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t              state_q;
    logic [DATA_BIT-1:0] data_q;
    logic [DATA_BIT-1:0] freq_q;
    logic [LW-1:0]       len_q;
    logic [CNT_BIT-1:0]  hp_q;
    logic [CNT_BIT-1:0]  lp_q;
    logic [REP_BIT-1:0]  pass_q;
    logic [IW-1:0]       idx_q;
    logic [CNT_BIT-1:0]  cnt_q;

`ifdef SERIAL_OUT_SHADOW_EN
    logic                sh_v_q;
    logic [DATA_BIT-1:0] sh_data_q;
    logic [DATA_BIT-1:0] sh_freq_q;
    logic [LW-1:0]       sh_len_q;
    logic [CNT_BIT-1:0]  sh_hp_q;
    logic [CNT_BIT-1:0]  sh_lp_q;
    logic [REP_BIT-1:0]  sh_rep_q;
`endif

    // Input config with zero/out-of-range values already normalised
    logic [LW-1:0]      in_len;
    logic [CNT_BIT-1:0] in_hp;
    logic [CNT_BIT-1:0] in_lp;

    assign in_len = (bus.i_bit_len == '0 || bus.i_bit_len > LW'(DATA_BIT))
                    ? LW'(DATA_BIT) : bus.i_bit_len;
    assign in_hp  = (bus.i_high_period == '0) ? CNT_BIT'(1) : bus.i_high_period;
    assign in_lp  = (bus.i_low_period == '0) ? CNT_BIT'(1) : bus.i_low_period;

    logic               busy;
    logic               pass_end;
    logic [IW-1:0]      nsel;
    logic [CNT_BIT-1:0] nper;

    assign busy     = (state_q == S_SHIFT);
    assign pass_end = busy && (cnt_q == '0) && ({1'b0, idx_q} == len_q - LW'(1));
    assign nsel     = pass_end ? '0 : idx_q + IW'(1);
    assign nper     = freq_q[nsel] ? hp_q : lp_q;

    // Load request: a fresh start taken from the inputs or the shadow
    logic                load;
    logic [DATA_BIT-1:0] ld_data;
    logic [DATA_BIT-1:0] ld_freq;
    logic [LW-1:0]       ld_len;
    logic [CNT_BIT-1:0]  ld_hp;
    logic [CNT_BIT-1:0]  ld_lp;
    logic [REP_BIT-1:0]  ld_rep;
    logic [CNT_BIT-1:0]  ld_per0;

    always_comb begin
        load    = 1'b0;
        ld_data = bus.i_output_pattern;
        ld_freq = bus.i_freq_pattern;
        ld_len  = in_len;
        ld_hp   = in_hp;
        ld_lp   = in_lp;
        ld_rep  = bus.i_repeat_num;
        if (!bus.i_stop && bus.i_start) begin
`ifdef SERIAL_OUT_SHADOW_EN
            // While shifting, a start coinciding with a pass end is taken
            // directly; otherwise it only fills the shadow.
            load = !busy || pass_end;
`else
            load = 1'b1;
`endif
        end
`ifdef SERIAL_OUT_SHADOW_EN
        else if (!bus.i_stop && pass_end && sh_v_q) begin
            load    = 1'b1;
            ld_data = sh_data_q;
            ld_freq = sh_freq_q;
            ld_len  = sh_len_q;
            ld_hp   = sh_hp_q;
            ld_lp   = sh_lp_q;
            ld_rep  = sh_rep_q;
        end
`endif
        ld_per0 = ld_freq[0] ? ld_hp : ld_lp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            freq_q  <= '0;
            len_q   <= '0;
            hp_q    <= '0;
            lp_q    <= '0;
            pass_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
`ifdef SERIAL_OUT_SHADOW_EN
            sh_v_q    <= 1'b0;
            sh_data_q <= '0;
            sh_freq_q <= '0;
            sh_len_q  <= '0;
            sh_hp_q   <= '0;
            sh_lp_q   <= '0;
            sh_rep_q  <= '0;
`endif
        end else if (load) begin
            state_q <= S_SHIFT;
            data_q  <= ld_data;
            freq_q  <= ld_freq;
            len_q   <= ld_len;
            hp_q    <= ld_hp;
            lp_q    <= ld_lp;
            pass_q  <= ld_rep;
            idx_q   <= '0;
            cnt_q   <= ld_per0 - CNT_BIT'(1);
`ifdef SERIAL_OUT_SHADOW_EN
            sh_v_q  <= 1'b0;
`endif
        end else if (busy) begin
            if (bus.i_stop) begin
                state_q <= S_IDLE;
                idx_q   <= '0;
                cnt_q   <= '0;
`ifdef SERIAL_OUT_SHADOW_EN
                sh_v_q  <= 1'b0;
`endif
            end else begin
`ifdef SERIAL_OUT_SHADOW_EN
                if (bus.i_start) begin
                    sh_v_q    <= 1'b1;
                    sh_data_q <= bus.i_output_pattern;
                    sh_freq_q <= bus.i_freq_pattern;
                    sh_len_q  <= in_len;
                    sh_hp_q   <= in_hp;
                    sh_lp_q   <= in_lp;
                    sh_rep_q  <= bus.i_repeat_num;
                end
`endif
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_BIT'(1);
                end else if (!pass_end) begin
                    idx_q <= idx_q + IW'(1);
                    cnt_q <= nper - CNT_BIT'(1);
                end else if (pass_q != REP_BIT'(1)) begin
                    // pass_q == 0 means continuous and is never decremented
                    idx_q <= '0;
                    cnt_q <= nper - CNT_BIT'(1);
                    if (pass_q != '0) pass_q <= pass_q - REP_BIT'(1);
                end else begin
                    state_q <= S_IDLE;
                    idx_q   <= '0;
                    pass_q  <= '0;
                end
            end
        end
    end

    assign bus.o_serial_out = busy ? data_q[idx_q] : IDLE_LEVEL;
    assign bus.o_bit_tick   = busy && (cnt_q == '0);
    assign bus.o_done_tick  = pass_end;
    assign bus.o_busy       = busy;

endmodule

// File: tb/tb_serial_out_prog.sv
// Directed testbench for serial_out_prog.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_serial_out_prog;
    localparam int DB = 32;
    localparam int CB = 8;
    localparam int RB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    serial_out_prog_if #(.DATA_BIT(DB), .CNT_BIT(CB), .REP_BIT(RB)) bus ();

    serial_out_prog #(
        .DATA_BIT(DB), .CNT_BIT(CB), .REP_BIT(RB), .IDLE_LEVEL(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // {serial, bit_tick, done_tick, busy}
    function automatic logic [3:0] obs();
        return {bus.o_serial_out, bus.o_bit_tick, bus.o_done_tick, bus.o_busy};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_cfg(input logic [31:0] pat, input logic [31:0] frq,
                           input logic [5:0] len, input logic [7:0] hp,
                           input logic [7:0] lp, input logic [7:0] rep);
        bus.i_output_pattern = pat;
        bus.i_freq_pattern   = frq;
        bus.i_bit_len        = len;
        bus.i_high_period    = hp;
        bus.i_low_period     = lp;
        bus.i_repeat_num     = rep;
    endtask

    // Returns at the falling edge inside the first cycle of bit0
    task automatic start_pulse();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            total++;
            if (obs() !== 4'b0000)
                $display("FAIL reset_idle cyc%0d got %b want 0000", c, obs());
            else passed++;
            step();
        end
        // stop alone while idle is ignored
        bus.i_stop = 1'b1;
        step();
        bus.i_stop = 1'b0;
        total++;
        if (obs() !== 4'b0000)
            $display("FAIL idle_stop got %b want 0000", obs());
        else passed++;
    endtask

    task automatic test_reset_mid();
        set_cfg(32'hFFFF_FFFF, 32'h0, 6'd0, 8'd3, 8'd9, 8'd0);
        start_pulse();
        step();
        step();
        total++;
        if (obs() !== 4'b1001)
            $display("FAIL rst_mid_pre got %b want 1001", obs());
        else passed++;
        rst = 1'b1;
        step();
        total++;
        if (obs() !== 4'b0000)
            $display("FAIL rst_mid got %b want 0000", obs());
        else passed++;
        rst = 1'b0;
        step();
        total++;
        if (obs() !== 4'b0000)
            $display("FAIL rst_mid_after got %b want 0000", obs());
        else passed++;
    endtask

    task automatic test_full_pattern();
        logic [31:0] pat;
        int bt;
        int dt;
        int bad;
        int per;
        logic [3:0] exp;
        pat = 32'h0000_00A5;
        bt = 0;
        dt = 0;
        bad = 0;
        set_cfg(pat, 32'h0000_000F, 6'd0, 8'd3, 8'd9, 8'd1);
        start_pulse();
        // later input changes must not affect the running pass
        set_cfg(32'h5A5A_5A5A, 32'hFFFF_0000, 6'd3, 8'd1, 8'd1, 8'd7);
        for (int k = 0; k < 32; k++) begin
            per = (k < 4) ? 3 : 9;
            for (int j = 0; j < per; j++) begin
                exp = {pat[k], j == per - 1, (k == 31) && (j == per - 1), 1'b1};
                if (bus.o_bit_tick) bt++;
                if (bus.o_done_tick) dt++;
                if (obs() !== exp) begin
                    if (bad < 4)
                        $display("FAIL full_wave bit%0d cyc%0d got %b want %b",
                                 k, j, obs(), exp);
                    bad++;
                end
                step();
            end
        end
        total++;
        if (bad != 0) $display("FAIL full_wave mismatches %0d want 0", bad);
        else passed++;
        total++;
        if (bt != 32) $display("FAIL full_bit_ticks got %0d want 32", bt);
        else passed++;
        total++;
        if (dt != 1) $display("FAIL full_done_ticks got %0d want 1", dt);
        else passed++;
        total++;
        if (obs() !== 4'b0000)
            $display("FAIL full_idle got %b want 0000", obs());
        else passed++;
    endtask

    task automatic test_repeat();
        logic [3:0] pat;
        logic [3:0] exp;
        int dt;
        int bad;
        pat = 4'b1010;
        dt = 0;
        bad = 0;
        set_cfg(32'h0000_000A, 32'h0, 6'd4, 8'd5, 8'd2, 8'd3);
        start_pulse();
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 2; j++) begin
                    exp = {pat[k], j == 1, (k == 3) && (j == 1), 1'b1};
                    if (bus.o_done_tick) dt++;
                    if (obs() !== exp) begin
                        if (bad < 4)
                            $display("FAIL rep_wave p%0d b%0d got %b want %b",
                                     p, k, obs(), exp);
                        bad++;
                    end
                    step();
                end
            end
        end
        total++;
        if (bad != 0) $display("FAIL rep_wave mismatches %0d want 0", bad);
        else passed++;
        total++;
        if (dt != 3) $display("FAIL rep_done_ticks got %0d want 3", dt);
        else passed++;
        total++;
        if (obs() !== 4'b0000)
            $display("FAIL rep_busy_c25 got %b want 0000", obs());
        else passed++;
    endtask

    task automatic test_continuous_stop();
        logic [3:0] exp;
        set_cfg(32'h0000_0001, 32'h0000_0003, 6'd2, 8'd1, 8'd7, 8'd0);
        start_pulse();
        for (int c = 1; c <= 7; c++) begin
            exp = (c % 2 == 1) ? 4'b1101 : 4'b0111;
            total++;
            if (obs() !== exp)
                $display("FAIL cont_wave cyc%0d got %b want %b", c, obs(), exp);
            else passed++;
            if (c == 7) bus.i_stop = 1'b1;
            step();
        end
        bus.i_stop = 1'b0;
        total++;
        if (obs() !== 4'b0000)
            $display("FAIL cont_stop got %b want 0000", obs());
        else passed++;
    endtask

    task automatic test_zero_period();
        logic [3:0] exp [0:3];
        exp[0] = 4'b0101;
        exp[1] = 4'b1101;
        exp[2] = 4'b1111;
        exp[3] = 4'b0000;
        set_cfg(32'h0000_0006, 32'h0000_0002, 6'd3, 8'd0, 8'd0, 8'd1);
        start_pulse();
        for (int c = 0; c < 4; c++) begin
            total++;
            if (obs() !== exp[c])
                $display("FAIL zero_per cyc%0d got %b want %b", c + 1, obs(), exp[c]);
            else passed++;
            step();
        end
    endtask

    task automatic test_start_stop_busy();
        set_cfg(32'hFFFF_FFFF, 32'h0, 6'd0, 8'd1, 8'd9, 8'd0);
        start_pulse();
        step();
        step();
        total++;
        if (obs() !== 4'b1001)
            $display("FAIL ss_pre got %b want 1001", obs());
        else passed++;
        bus.i_start = 1'b1;
        bus.i_stop  = 1'b1;
        step();
        total++;
        if (obs() !== 4'b0000)
            $display("FAIL ss_busy got %b want 0000", obs());
        else passed++;
        step();
        total++;
        if (obs() !== 4'b0000)
            $display("FAIL ss_idle got %b want 0000", obs());
        else passed++;
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
    endtask

    task automatic test_restart();
`ifdef SERIAL_OUT_SHADOW_EN
        localparam int N = 11;
        logic [3:0] exp [0:N-1];
        exp[0] = 4'b1001; exp[1] = 4'b1001; exp[2] = 4'b1101;
        exp[3] = 4'b1001; exp[4] = 4'b1001; exp[5] = 4'b1111;
        exp[6] = 4'b0001; exp[7] = 4'b0101; exp[8] = 4'b1001;
        exp[9] = 4'b1111; exp[10] = 4'b0000;
`else
        localparam int N = 7;
        logic [3:0] exp [0:N-1];
        exp[0] = 4'b1001; exp[1] = 4'b1001; exp[2] = 4'b0001;
        exp[3] = 4'b0101; exp[4] = 4'b1001; exp[5] = 4'b1111;
        exp[6] = 4'b0000;
`endif
        set_cfg(32'h0000_0003, 32'h0, 6'd2, 8'd2, 8'd3, 8'd0);
        start_pulse();
        for (int c = 0; c < N; c++) begin
            total++;
            if (obs() !== exp[c])
                $display("FAIL restart cyc%0d got %b want %b", c + 1, obs(), exp[c]);
            else passed++;
            if (c == 1) begin
                set_cfg(32'h0000_0002, 32'h0000_0003, 6'd2, 8'd2, 8'd3, 8'd1);
                bus.i_start = 1'b1;
            end else begin
                bus.i_start = 1'b0;
                if (c == 2)
                    set_cfg(32'hFFFF_FFFF, 32'h0, 6'd5, 8'd4, 8'd4, 8'd9);
            end
            step();
        end
        bus.i_start = 1'b0;
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        set_cfg(32'h0, 32'h0, 6'd0, 8'd0, 8'd0, 8'd0);
        step();
        test_reset();
        test_reset_mid();
        test_full_pattern();
        test_repeat();
        test_continuous_stop();
        test_zero_period();
        test_start_stop_busy();
        test_restart();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
